pl1_fetch: RTL

//   Parametrised fetch stage. It replaces the single-instruction fetch with a decoupled prefetcher.

---
 rtl/pl1_fetch_pkg.sv | 15 +
 rtl/pl1_fetch_fifo.sv | 58 +++++
 rtl/pl1_fetch.sv | 96 +++++++++
 3 files changed

// File: rtl/pl1_fetch_pkg.sv
// Shared types for the pl1 decoupled fetch stage.
// Instruction words, PC payloads and fetch control states.
package pl1_fetch_pkg;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] instr_val_t;

  localparam instr_t INSTR_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pl1_fetch_fifo.sv
// Prefetch queue for pl1_fetch.
// Wrap-around pointers carry an extra MSB to tell full from empty.
module pl1_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          do_push;
  logic          do_pop;

  assign o_count = wptr_q - rptr_q;
  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = i_pop && !o_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = i_push && (!o_full || do_pop);
  assign o_data  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (i_flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wptr_q[AW-1:0]] <= i_data;
  end

  a_no_overflow: assert property (
    @(posedge i_clk) disable iff (i_rst)
      !(i_push && !i_flush && o_full && !do_pop)
  );

endmodule

// File: rtl/pl1_fetch.sv
// pl1 decoupled fetch stage: credit-based prefetch into a small queue,
// valid/ready hand-off to decode, redirects flush and restart fetch.
module pl1_fetch
  import pl1_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_imem_req,
  output logic [XLEN-1:0]          o_imem_addr,
  input  logic [31:0]              i_imem_rdata,
  output logic                     o_instr_valid,
  output logic [31:0]              o_instr,
  output logic [XLEN-1:0]          o_instr_pc,
  input  logic                     i_instr_ready,
  input  logic                     i_redirect_valid,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_misalign,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ifl_pc_q;
  logic             ifl_q;
  logic             mis_q;
  logic [CW-1:0]    occ;
  logic [CW:0]      used;
  logic             full, empty;
  logic             req, push, pop, kill;
  logic [31+XLEN:0] head;

  // Credits count queue entries plus the response still on its way.
  assign used = {1'b0, occ} + {{CW{1'b0}}, ifl_q};
  assign req  = !i_rst && !i_redirect_valid && !full &&
                (used < (CW+1)'(DEPTH));
  assign kill = (state_q == FLUSH);
  assign push = ifl_q && !kill;
  assign pop  = !empty && i_instr_ready;

  always_comb begin
    state_d = i_redirect_valid ? FLUSH : RUN;
    pc_d    = pc_q;
    unique case (1'b1)
      i_redirect_valid: pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
      req:              pc_d = pc_q + XLEN'(4);
      default:          pc_d = pc_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      ifl_q    <= 1'b0;
      ifl_pc_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ifl_q    <= req;
      if (req) ifl_pc_q <= pc_q;
      mis_q    <= i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    end
  end

  pl1_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + XLEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  ({i_imem_rdata, ifl_pc_q}),
    .i_pop   (pop),
    .i_flush (i_redirect_valid),
    .o_data  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (occ)
  );

  assign o_imem_req    = req;
  assign o_imem_addr   = pc_q;
  assign o_instr_valid = !empty;
  assign o_instr       = empty ? INSTR_NOP : head[31+XLEN:XLEN];
  assign o_instr_pc    = empty ? '0 : head[XLEN-1:0];
  assign o_misalign    = mis_q;
  assign o_occupancy   = occ;

endmodule
